// File: rtl/rifl_sched_pkg.sv
// Shared types and the rotate-priority search used by the FIFO round-robin scheduler.
package rifl_sched_pkg;

    localparam int MAX_CH    = 16;
    localparam int MAX_IDX_W = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE  = ST_IDLE,
        S_BURST = ST_BURST
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of eligible searching ptr+1, ptr+2, ... modulo n.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0]    eligible,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int                   n);
        pick_t r;
        int    c;
        r = '0;
        for (int k = 1; k <= MAX_CH; k++) begin
            c = (int'(ptr) + k) % n;
            if (!r.valid && k <= n && eligible[c[MAX_IDX_W-1:0]]) begin
                r.valid = 1'b1;
                r.idx   = c[MAX_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rifl_rr_picker.sv
// Combinational rotate-priority encoder: picks the next eligible index after ptr.
module rifl_rr_picker
    import rifl_sched_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  eligible,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [MAX_CH-1:0]    elig_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    pick_t                pick;
    logic                 unused_pick_bits;

    always_comb begin
        elig_ext           = '0;
        elig_ext[N_CH-1:0] = eligible;
        ptr_ext            = '0;
        ptr_ext[IDX_W-1:0] = ptr;
        pick               = rr_pick(elig_ext, ptr_ext, N_CH);
    end

    assign gnt_valid        = pick.valid;
    assign gnt_idx          = pick.idx[IDX_W-1:0];
    // Upper index bits are always zero for N_CH below MAX_CH.
    assign unused_pick_bits = ^pick.idx;

endmodule

// File: rtl/rifl_fifo_rr_sched.sv
// Round-robin drain of N_CH FWFT FIFOs into one registered valid/ready stream,
// granting each channel a burst of up to BURST beats.
module rifl_fifo_rr_sched
    import rifl_sched_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DWIDTH = 32,
    parameter  int BURST  = 8,
    localparam int IDX_W  = $clog2(N_CH),
    localparam int CNT_W  = $clog2(BURST) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        ch_empty,
    input  logic [N_CH*DWIDTH-1:0] ch_data,
    output logic [N_CH-1:0]        ch_rd_en,
    input  logic [N_CH-1:0]        ch_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DWIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]       out_ch,
    output logic                   out_last,
    output logic                   busy
);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DWIDTH-1:0]  out_data_q,  out_data_d;
    logic [IDX_W-1:0]   out_ch_q,    out_ch_d;
    logic               out_last_q,  out_last_d;

    logic [N_CH-1:0]    eligible;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;
    logic               grant_ok;
    logic               pop;
    logic               quota;

    assign eligible = ch_en & ~ch_empty;

    rifl_rr_picker #(
        .N_CH      (N_CH)
    ) u_picker (
        .eligible  (eligible),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // rr_ptr_q doubles as the active grant while in S_BURST.
    always_comb begin
        grant_ok    = eligible[rr_ptr_q];
        pop         = (state_q == S_BURST) && grant_ok && (!out_valid_q || out_ready);
        quota       = (beat_cnt_q == CNT_W'(BURST - 1));

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        ch_rd_en    = '0;

        if (!pop && out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_valid) begin
                    state_d    = S_BURST;
                    rr_ptr_d   = gnt_idx;
                    beat_cnt_d = '0;
                end
            end
            S_BURST: begin
                if (pop) begin
                    ch_rd_en[rr_ptr_q] = 1'b1;
                    out_data_d  = ch_data[rr_ptr_q*DWIDTH +: DWIDTH];
                    out_ch_d    = rr_ptr_q;
                    out_valid_d = 1'b1;
                    out_last_d  = quota;
                    beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                    if (quota) begin
                        state_d = S_IDLE;
                    end
                end else if (!grant_ok) begin
                    // A stalled downstream keeps the grant; only empty/disabled ends it.
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= IDX_W'(N_CH - 1);
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == S_BURST);

endmodule

// File: tb/tb_rifl_fifo_rr_sched.sv
// Bench for rifl_fifo_rr_sched: FIFO queues feed the DUT, a transaction model predicts every cycle.
module tb_rifl_fifo_rr_sched;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int BA  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_empty_a, ch_rd_en_a, ch_en_a;
    logic [NCH*DW-1:0] ch_data_a;
    logic              out_valid_a, out_ready_a, out_last_a, busy_a;
    logic [DW-1:0]     out_data_a;
    logic [1:0]        out_ch_a;

    logic [NCH-1:0]    ch_empty_b, ch_rd_en_b, ch_en_b;
    logic [NCH*DW-1:0] ch_data_b;
    logic              out_valid_b, out_ready_b, out_last_b, busy_b;
    logic [DW-1:0]     out_data_b;
    logic [1:0]        out_ch_b;

    rifl_fifo_rr_sched #(.N_CH(NCH), .DWIDTH(DW), .BURST(BA)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch_empty(ch_empty_a), .ch_data(ch_data_a),
        .ch_rd_en(ch_rd_en_a), .ch_en(ch_en_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_ch(out_ch_a),
        .out_last(out_last_a), .busy(busy_a)
    );

    rifl_fifo_rr_sched #(.N_CH(NCH), .DWIDTH(DW), .BURST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_empty(ch_empty_b), .ch_data(ch_data_b),
        .ch_rd_en(ch_rd_en_b), .ch_en(ch_en_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_ch(out_ch_b),
        .out_last(out_last_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int ch;
        bit last;
        int cyc;
    } beat_t;

    beat_t trace_a[$];
    beat_t trace_b[$];
    int    exp_ch[$];
    bit    exp_last[$];

    // Channel FIFOs: word k of channel c carries {c, k}; head/tail are word counts.
    int head_a[NCH];
    int tail_a[NCH];

    function automatic logic [DW-1:0] word(int c, int s);
        return DW'(c * 65536 + s);
    endfunction

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_empty_a[i]          = (head_a[i] == tail_a[i]);
            ch_data_a[i*DW +: DW]  = word(i, head_a[i]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n)             head_a[i] <= tail_a[i];
            else if (ch_rd_en_a[i]) head_a[i] <= head_a[i] + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: grant owner (-1 when idle), beats taken, output register, next seq per channel.
    int           m_grant = -1;
    int           m_ptr   = NCH - 1;
    int           m_taken = 0;
    bit           m_vld   = 1'b0;
    bit           m_lastf = 1'b0;
    int           m_ch    = 0;
    logic [DW-1:0] m_word = '0;
    int           m_seq[NCH];

    function automatic bit m_elig(int c);
        return ch_en_a[c] && !ch_empty_a[c];
    endfunction

    function automatic bit m_pop();
        return (m_grant >= 0) && m_elig(m_grant) && (!m_vld || out_ready_a);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit p;
        bit found;
        int c;
        if (!rst_n) begin
            m_grant = -1;
            m_ptr   = NCH - 1;
            m_taken = 0;
            m_vld   = 1'b0;
            m_lastf = 1'b0;
            m_ch    = 0;
            m_word  = '0;
            for (int i = 0; i < NCH; i++) m_seq[i] = tail_a[i];
        end else begin
            p = m_pop();
            if (!p && m_vld && out_ready_a) m_vld = 1'b0;
            if (m_grant < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_ptr + k) % NCH;
                    if (!found && m_elig(c)) begin
                        found   = 1'b1;
                        m_grant = c;
                        m_ptr   = c;
                        m_taken = 0;
                    end
                end
            end else if (p) begin
                m_vld   = 1'b1;
                m_ch    = m_grant;
                m_word  = word(m_grant, m_seq[m_grant]);
                m_seq[m_grant]++;
                m_lastf = (m_taken == BA - 1);
                m_taken++;
                if (m_taken == BA) m_grant = -1;
            end else if (!m_elig(m_grant)) begin
                m_grant = -1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] erd;
        if (rst_n === 1'b1) begin
            erd = '0;
            if (m_pop()) erd[m_grant] = 1'b1;
            chk("rd_en",     64'(ch_rd_en_a),  64'(erd));
            chk("out_valid", 64'(out_valid_a), 64'(m_vld));
            chk("busy",      64'(busy_a),      64'(m_grant >= 0));
            if (m_vld) begin
                chk("out_data", 64'(out_data_a), 64'(m_word));
                chk("out_ch",   64'(out_ch_a),   64'(m_ch));
                chk("out_last", 64'(out_last_a), 64'(m_lastf));
            end
            if (out_valid_a && out_ready_a)
                trace_a.push_back('{ch: int'(out_ch_a), last: out_last_a, cyc: cyc});
            if (out_valid_b && out_ready_b)
                trace_b.push_back('{ch: int'(out_ch_b), last: out_last_b, cyc: cyc});
        end
    end

    task automatic add_grant(int c, int n);
        for (int k = 0; k < n; k++) begin
            exp_ch.push_back(c);
            exp_last.push_back(k == BA - 1);
        end
    endtask

    task automatic wait_count(int n, string name);
        int b = 0;
        while (trace_a.size() < n && b < 600) begin
            @(posedge clk);
            b++;
        end
        if (trace_a.size() < n) chk({name, "_timeout"}, 64'(trace_a.size()), 64'(n));
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic wait_head(int c, int val, string name);
        int b = 0;
        do begin
            @(posedge clk);
            #1;
            b++;
        end while (head_a[c] < val && b < 600);
        if (head_a[c] < val) chk({name, "_timeout"}, 64'(head_a[c]), 64'(val));
    endtask

    task automatic check_phase(int ph, string name);
        int n;
        chk({name, "_count"}, 64'(trace_a.size() - ph), 64'(exp_ch.size()));
        n = exp_ch.size();
        if (trace_a.size() - ph < n) n = trace_a.size() - ph;
        for (int k = 0; k < n; k++)
            chk($sformatf("%s[%0d] ch*2+last", name, k),
                64'(trace_a[ph+k].ch * 2 + int'(trace_a[ph+k].last)),
                64'(exp_ch[k] * 2 + int'(exp_last[k])));
        exp_ch.delete();
        exp_last.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ph;
        int base0, base1, base3;
        logic [DW-1:0] h_data;
        logic [1:0]    h_ch;
        logic          h_last;

        rst_n       = 1'b0;
        out_ready_a = 1'b1;
        ch_en_a     = '1;
        out_ready_b = 1'b1;
        ch_en_b     = 4'b0011;
        ch_empty_b  = 4'b1100;
        ch_data_b   = {word(3, 0), word(2, 0), word(1, 0), word(0, 0)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_a), 64'(0));
        chk("rst_out_data",  64'(out_data_a),  64'(0));
        chk("rst_out_ch",    64'(out_ch_a),    64'(0));
        chk("rst_out_last",  64'(out_last_a),  64'(0));
        chk("rst_busy",      64'(busy_a),      64'(0));
        chk("rst_rd_en_b",   64'(ch_rd_en_b),  64'(0));
        rst_n = 1'b1;

        // All four channels full: 8-beat bursts in channel order, one bubble per grant.
        ph = trace_a.size();
        for (int c = 0; c < NCH; c++) tail_a[c] += 20;
        for (int r = 0; r < 2; r++) for (int c = 0; c < NCH; c++) add_grant(c, 8);
        for (int c = 0; c < NCH; c++) add_grant(c, 4);
        wait_count(ph + 80, "p1");
        if (trace_a.size() >= ph + 9) begin
            chk("gap_in_burst",   64'(trace_a[ph+1].cyc - trace_a[ph].cyc),   64'(1));
            chk("gap_over_grant", 64'(trace_a[ph+8].cyc - trace_a[ph+7].cyc), 64'(2));
        end
        check_phase(ph, "p1");

        // BURST=1 instance: strict alternation, every beat last.
        chk("b1_count_ok", 64'(trace_b.size() >= 8), 64'(1));
        if (trace_b.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("b1_ch[%0d]", k),   64'(trace_b[k].ch),   64'(k % 2));
                chk($sformatf("b1_last[%0d]", k), 64'(trace_b[k].last), 64'(1));
            end
            chk("b1_gap", 64'(trace_b[1].cyc - trace_b[0].cyc), 64'(2));
        end

        // Short channel 2 plus a 5-cycle downstream stall early in the first burst.
        ph = trace_a.size();
        tail_a[0] += 20; tail_a[1] += 20; tail_a[2] += 3; tail_a[3] += 20;
        add_grant(0, 8); add_grant(1, 8); add_grant(2, 3); add_grant(3, 8);
        add_grant(0, 8); add_grant(1, 8); add_grant(3, 8);
        add_grant(0, 4); add_grant(1, 4); add_grant(3, 4);
        begin
            int b = 0;
            do begin
                @(posedge clk);
                #1;
                b++;
            end while (trace_a.size() < ph + 3 && b < 600);
        end
        out_ready_a = 1'b0;
        h_data = out_data_a;
        h_ch   = out_ch_a;
        h_last = out_last_a;
        chk("stall_valid", 64'(out_valid_a), 64'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_data",  64'(out_data_a), 64'(h_data));
            chk("stall_ch",    64'(out_ch_a),   64'(h_ch));
            chk("stall_last",  64'(out_last_a), 64'(h_last));
            chk("stall_rd_en", 64'(ch_rd_en_a), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        wait_count(ph + 63, "p2");
        check_phase(ph, "p2");

        // Channel 1 disabled after its 4th pop, re-enabled during channel 3's grant.
        ph    = trace_a.size();
        base1 = head_a[1];
        base3 = head_a[3];
        for (int c = 0; c < NCH; c++) tail_a[c] += 12;
        add_grant(0, 8); add_grant(1, 4); add_grant(2, 8); add_grant(3, 8);
        add_grant(0, 4); add_grant(1, 8); add_grant(2, 4); add_grant(3, 4);
        wait_head(1, base1 + 4, "p3_ch1");
        ch_en_a[1] = 1'b0;
        wait_head(3, base3 + 1, "p3_ch3");
        ch_en_a[1] = 1'b1;
        wait_count(ph + 48, "p3");
        check_phase(ph, "p3");

        // Asynchronous reset between edges in the middle of channel 0's burst.
        base0 = head_a[0];
        tail_a[0] += 10;
        tail_a[1] += 10;
        wait_head(0, base0 + 3, "p4_ch0");
        chk("pre_rst_valid", 64'(out_valid_a), 64'(1));
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid_a), 64'(0));
        chk("arst_rd_en",     64'(ch_rd_en_a),  64'(0));
        chk("arst_busy",      64'(busy_a),      64'(0));
        chk("arst_out_data",  64'(out_data_a),  64'(0));
        chk("arst_valid_b",   64'(out_valid_b), 64'(0));
        chk("arst_busy_b",    64'(busy_b),      64'(0));
        chk("arst_data_b",    64'(out_data_b),  64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ph = trace_a.size();
        tail_a[0] += 5;
        tail_a[1] += 5;
        add_grant(0, 5); add_grant(1, 5);
        wait_count(ph + 10, "p4");
        if (trace_a.size() > ph) chk("first_after_rst", 64'(trace_a[ph].ch), 64'(0));
        check_phase(ph, "p4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rifl_fifo_rr_sched.md
Name: rifl_fifo_rr_sched

Overview:
- Round-robin scheduler that drains N_CH first-word-fall-through sync FIFOs (rifl_sync_fifo instances, one per channel) into one registered output stream.
- Each grant lasts a burst of up to BURST beats, then rotates to the next channel.
- Sits between the per-channel receive buffers and the shared downstream datapath, for example a merge into a single lane or a DMA writer.
- The output is valid/ready with a channel tag and an end-of-quota marker.

Parameters:
- N_CH, 4, number of channels; 2..16.
- DWIDTH, 32, data width per beat.
- BURST, 8, maximum beats popped per grant; 1..256.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous assert, active-low.
- ch_empty  in  N_CH  per-channel FIFO rd_empty (FWFT).
- ch_data  in  N_CH*DWIDTH  per-channel FIFO rd_data; channel i occupies [i*DWIDTH +: DWIDTH].
- ch_rd_en  out  N_CH  per-channel FIFO rd_en; at most one bit set per cycle.
- ch_en  in  N_CH  channel enable mask; disabled channels are never granted or popped.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DWIDTH  output beat.
- out_ch  out  $clog2(N_CH)  source channel of the beat.
- out_last  out  1  beat is the BURST-th beat of its grant.
- busy  out  1  a grant is active (state BURST).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, rr_ptr=N_CH-1, so the first pick is channel 0.
  - beat_cnt=0, out_valid=0, out_data=0, out_ch=0, out_last=0, busy=0.
  - ch_rd_en is all 0 for as long as rst_n is low.
- Eligibility: eligible[i] = ch_en[i] & ~ch_empty[i].
- State IDLE:
  - If any channel is eligible, pick the first eligible index searching rr_ptr+1, rr_ptr+2, … (mod N_CH).
  - Register grant=pick, rr_ptr=pick, beat_cnt=0, and go to BURST next cycle.
  - No pop happens in IDLE, so each grant costs one bubble cycle.
- State BURST, pop rule:
  - pop = ch_en[grant] & ~ch_empty[grant] & (~out_valid | out_ready).
  - ch_rd_en[grant]=pop; all other bits are 0.
- On pop:
  - out_data<=ch_data[grant], out_ch<=grant, out_valid<=1.
  - out_last<=(beat_cnt==BURST-1).
  - beat_cnt<=beat_cnt+1.
- Without pop: if out_valid & out_ready, then out_valid<=0.
- Burst end, transition to IDLE:
  - After the pop where beat_cnt==BURST-1 (quota reached); or
  - In any BURST cycle where the granted channel is empty or disabled. The downstream-stalled case is not an end; the grant holds.
- Latency: a beat popped at cycle t is visible on out_* at t+1.
- Throughput: full rate within a burst while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_ch and out_last are held stable.
- beat_cnt width: $clog2(BURST)+1. It never wraps, because it resets on each grant.
- BURST=1: every beat ends its grant, with out_last=1 on every beat.
- N_CH with one eligible channel: that channel is re-granted each time, giving BURST beats then one bubble.
- ch_en deassert mid-burst: there is no further pop from that channel, and the burst ends that cycle. A beat already in the output register is still delivered.
- ch_empty glitch-free assumption: ch_empty and ch_data come from the same-clock FIFO (FWFT bypass allowed). Data is sampled only in the pop cycle.
- Simultaneous output accept and pop: the register is overwritten with no bubble.
- Reset mid-burst: state, pointers and the output register clear immediately. An undelivered beat is dropped; upstream FIFOs are reset by the same domain.
- Fairness: every eligible channel is granted within N_CH-1 intervening grants.

Decomposition:
- Package rifl_sched_pkg:
  - state enum {IDLE, BURST}.
  - function rr_pick(eligible, ptr, n), returning a valid flag and an index.
  - localparams for index/count widths.
- Sub-module rifl_rr_picker: combinational rotate-priority encoder (N_CH, eligible, ptr -> gnt_valid, gnt_idx), reusable by other arbiters.
- The main module holds the FSM, counters and the output register.

Test Plan:
- Reset then all channels non-empty with 20 words each, N_CH=4, BURST=8, out_ready=1:
  - Beats arrive in the order ch0×8, ch1×8, ch2×8, ch3×8, ch0×8, …
  - out_last is 1 on beats 8, 16, …
  - There is exactly one bubble between grants.
- Ch2 holds only 3 words, others full:
  - Ch2's grant yields 3 beats with out_last=0, then the grant ends and moves to ch3.
- out_ready held low for 5 cycles mid-burst:
  - out_data, out_ch and out_last stay stable.
  - ch_rd_en stays 0.
  - The burst resumes with no lost or duplicated word; check the sequence numbers.
- ch_en[1] cleared on the 4th beat of ch1's burst:
  - No further ch1 pops; the grant moves to ch2.
  - Ch1 is skipped until re-enabled, then rejoins at its round-robin turn.
- BURST=1, two channels active:
  - Beats strictly alternate ch0, ch1, ch0, …, each with out_last=1.
- rst_n pulsed low asynchronously mid-burst, between clock edges:
  - out_valid and ch_rd_en drop immediately.
  - After release, the first grant goes to channel 0.
